// File: rtl/key_schedule_iter_pkg.sv
// Shared definitions for the iterative AES key expander: block width, rcon handling,
// key-length legality and the controller state encoding.
package key_schedule_iter_pkg;

   localparam int NB = 4;
   localparam logic [7:0] RCON_RST = 8'h01;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } ks_state_e;

   function automatic bit key_len_ok(input int key_len);
      return (key_len == 128) || (key_len == 192) || (key_len == 256);
   endfunction

   // GF(2^8) multiply by x, reduction polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/key_schedule_iter_sbox.sv
// Forward AES S-box, one byte, as a combinational lookup table.
module aes_sbox_byte (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   always_comb begin
      out_byte = 8'h00;
      case (in_byte)
         8'h00: out_byte = 8'h63; 8'h01: out_byte = 8'h7c; 8'h02: out_byte = 8'h77; 8'h03: out_byte = 8'h7b; 8'h04: out_byte = 8'hf2; 8'h05: out_byte = 8'h6b; 8'h06: out_byte = 8'h6f; 8'h07: out_byte = 8'hc5;
         8'h08: out_byte = 8'h30; 8'h09: out_byte = 8'h01; 8'h0a: out_byte = 8'h67; 8'h0b: out_byte = 8'h2b; 8'h0c: out_byte = 8'hfe; 8'h0d: out_byte = 8'hd7; 8'h0e: out_byte = 8'hab; 8'h0f: out_byte = 8'h76;
         8'h10: out_byte = 8'hca; 8'h11: out_byte = 8'h82; 8'h12: out_byte = 8'hc9; 8'h13: out_byte = 8'h7d; 8'h14: out_byte = 8'hfa; 8'h15: out_byte = 8'h59; 8'h16: out_byte = 8'h47; 8'h17: out_byte = 8'hf0;
         8'h18: out_byte = 8'had; 8'h19: out_byte = 8'hd4; 8'h1a: out_byte = 8'ha2; 8'h1b: out_byte = 8'haf; 8'h1c: out_byte = 8'h9c; 8'h1d: out_byte = 8'ha4; 8'h1e: out_byte = 8'h72; 8'h1f: out_byte = 8'hc0;
         8'h20: out_byte = 8'hb7; 8'h21: out_byte = 8'hfd; 8'h22: out_byte = 8'h93; 8'h23: out_byte = 8'h26; 8'h24: out_byte = 8'h36; 8'h25: out_byte = 8'h3f; 8'h26: out_byte = 8'hf7; 8'h27: out_byte = 8'hcc;
         8'h28: out_byte = 8'h34; 8'h29: out_byte = 8'ha5; 8'h2a: out_byte = 8'he5; 8'h2b: out_byte = 8'hf1; 8'h2c: out_byte = 8'h71; 8'h2d: out_byte = 8'hd8; 8'h2e: out_byte = 8'h31; 8'h2f: out_byte = 8'h15;
         8'h30: out_byte = 8'h04; 8'h31: out_byte = 8'hc7; 8'h32: out_byte = 8'h23; 8'h33: out_byte = 8'hc3; 8'h34: out_byte = 8'h18; 8'h35: out_byte = 8'h96; 8'h36: out_byte = 8'h05; 8'h37: out_byte = 8'h9a;
         8'h38: out_byte = 8'h07; 8'h39: out_byte = 8'h12; 8'h3a: out_byte = 8'h80; 8'h3b: out_byte = 8'he2; 8'h3c: out_byte = 8'heb; 8'h3d: out_byte = 8'h27; 8'h3e: out_byte = 8'hb2; 8'h3f: out_byte = 8'h75;
         8'h40: out_byte = 8'h09; 8'h41: out_byte = 8'h83; 8'h42: out_byte = 8'h2c; 8'h43: out_byte = 8'h1a; 8'h44: out_byte = 8'h1b; 8'h45: out_byte = 8'h6e; 8'h46: out_byte = 8'h5a; 8'h47: out_byte = 8'ha0;
         8'h48: out_byte = 8'h52; 8'h49: out_byte = 8'h3b; 8'h4a: out_byte = 8'hd6; 8'h4b: out_byte = 8'hb3; 8'h4c: out_byte = 8'h29; 8'h4d: out_byte = 8'he3; 8'h4e: out_byte = 8'h2f; 8'h4f: out_byte = 8'h84;
         8'h50: out_byte = 8'h53; 8'h51: out_byte = 8'hd1; 8'h52: out_byte = 8'h00; 8'h53: out_byte = 8'hed; 8'h54: out_byte = 8'h20; 8'h55: out_byte = 8'hfc; 8'h56: out_byte = 8'hb1; 8'h57: out_byte = 8'h5b;
         8'h58: out_byte = 8'h6a; 8'h59: out_byte = 8'hcb; 8'h5a: out_byte = 8'hbe; 8'h5b: out_byte = 8'h39; 8'h5c: out_byte = 8'h4a; 8'h5d: out_byte = 8'h4c; 8'h5e: out_byte = 8'h58; 8'h5f: out_byte = 8'hcf;
         8'h60: out_byte = 8'hd0; 8'h61: out_byte = 8'hef; 8'h62: out_byte = 8'haa; 8'h63: out_byte = 8'hfb; 8'h64: out_byte = 8'h43; 8'h65: out_byte = 8'h4d; 8'h66: out_byte = 8'h33; 8'h67: out_byte = 8'h85;
         8'h68: out_byte = 8'h45; 8'h69: out_byte = 8'hf9; 8'h6a: out_byte = 8'h02; 8'h6b: out_byte = 8'h7f; 8'h6c: out_byte = 8'h50; 8'h6d: out_byte = 8'h3c; 8'h6e: out_byte = 8'h9f; 8'h6f: out_byte = 8'ha8;
         8'h70: out_byte = 8'h51; 8'h71: out_byte = 8'ha3; 8'h72: out_byte = 8'h40; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'h92; 8'h75: out_byte = 8'h9d; 8'h76: out_byte = 8'h38; 8'h77: out_byte = 8'hf5;
         8'h78: out_byte = 8'hbc; 8'h79: out_byte = 8'hb6; 8'h7a: out_byte = 8'hda; 8'h7b: out_byte = 8'h21; 8'h7c: out_byte = 8'h10; 8'h7d: out_byte = 8'hff; 8'h7e: out_byte = 8'hf3; 8'h7f: out_byte = 8'hd2;
         8'h80: out_byte = 8'hcd; 8'h81: out_byte = 8'h0c; 8'h82: out_byte = 8'h13; 8'h83: out_byte = 8'hec; 8'h84: out_byte = 8'h5f; 8'h85: out_byte = 8'h97; 8'h86: out_byte = 8'h44; 8'h87: out_byte = 8'h17;
         8'h88: out_byte = 8'hc4; 8'h89: out_byte = 8'ha7; 8'h8a: out_byte = 8'h7e; 8'h8b: out_byte = 8'h3d; 8'h8c: out_byte = 8'h64; 8'h8d: out_byte = 8'h5d; 8'h8e: out_byte = 8'h19; 8'h8f: out_byte = 8'h73;
         8'h90: out_byte = 8'h60; 8'h91: out_byte = 8'h81; 8'h92: out_byte = 8'h4f; 8'h93: out_byte = 8'hdc; 8'h94: out_byte = 8'h22; 8'h95: out_byte = 8'h2a; 8'h96: out_byte = 8'h90; 8'h97: out_byte = 8'h88;
         8'h98: out_byte = 8'h46; 8'h99: out_byte = 8'hee; 8'h9a: out_byte = 8'hb8; 8'h9b: out_byte = 8'h14; 8'h9c: out_byte = 8'hde; 8'h9d: out_byte = 8'h5e; 8'h9e: out_byte = 8'h0b; 8'h9f: out_byte = 8'hdb;
         8'ha0: out_byte = 8'he0; 8'ha1: out_byte = 8'h32; 8'ha2: out_byte = 8'h3a; 8'ha3: out_byte = 8'h0a; 8'ha4: out_byte = 8'h49; 8'ha5: out_byte = 8'h06; 8'ha6: out_byte = 8'h24; 8'ha7: out_byte = 8'h5c;
         8'ha8: out_byte = 8'hc2; 8'ha9: out_byte = 8'hd3; 8'haa: out_byte = 8'hac; 8'hab: out_byte = 8'h62; 8'hac: out_byte = 8'h91; 8'had: out_byte = 8'h95; 8'hae: out_byte = 8'he4; 8'haf: out_byte = 8'h79;
         8'hb0: out_byte = 8'he7; 8'hb1: out_byte = 8'hc8; 8'hb2: out_byte = 8'h37; 8'hb3: out_byte = 8'h6d; 8'hb4: out_byte = 8'h8d; 8'hb5: out_byte = 8'hd5; 8'hb6: out_byte = 8'h4e; 8'hb7: out_byte = 8'ha9;
         8'hb8: out_byte = 8'h6c; 8'hb9: out_byte = 8'h56; 8'hba: out_byte = 8'hf4; 8'hbb: out_byte = 8'hea; 8'hbc: out_byte = 8'h65; 8'hbd: out_byte = 8'h7a; 8'hbe: out_byte = 8'hae; 8'hbf: out_byte = 8'h08;
         8'hc0: out_byte = 8'hba; 8'hc1: out_byte = 8'h78; 8'hc2: out_byte = 8'h25; 8'hc3: out_byte = 8'h2e; 8'hc4: out_byte = 8'h1c; 8'hc5: out_byte = 8'ha6; 8'hc6: out_byte = 8'hb4; 8'hc7: out_byte = 8'hc6;
         8'hc8: out_byte = 8'he8; 8'hc9: out_byte = 8'hdd; 8'hca: out_byte = 8'h74; 8'hcb: out_byte = 8'h1f; 8'hcc: out_byte = 8'h4b; 8'hcd: out_byte = 8'hbd; 8'hce: out_byte = 8'h8b; 8'hcf: out_byte = 8'h8a;
         8'hd0: out_byte = 8'h70; 8'hd1: out_byte = 8'h3e; 8'hd2: out_byte = 8'hb5; 8'hd3: out_byte = 8'h66; 8'hd4: out_byte = 8'h48; 8'hd5: out_byte = 8'h03; 8'hd6: out_byte = 8'hf6; 8'hd7: out_byte = 8'h0e;
         8'hd8: out_byte = 8'h61; 8'hd9: out_byte = 8'h35; 8'hda: out_byte = 8'h57; 8'hdb: out_byte = 8'hb9; 8'hdc: out_byte = 8'h86; 8'hdd: out_byte = 8'hc1; 8'hde: out_byte = 8'h1d; 8'hdf: out_byte = 8'h9e;
         8'he0: out_byte = 8'he1; 8'he1: out_byte = 8'hf8; 8'he2: out_byte = 8'h98; 8'he3: out_byte = 8'h11; 8'he4: out_byte = 8'h69; 8'he5: out_byte = 8'hd9; 8'he6: out_byte = 8'h8e; 8'he7: out_byte = 8'h94;
         8'he8: out_byte = 8'h9b; 8'he9: out_byte = 8'h1e; 8'hea: out_byte = 8'h87; 8'heb: out_byte = 8'he9; 8'hec: out_byte = 8'hce; 8'hed: out_byte = 8'h55; 8'hee: out_byte = 8'h28; 8'hef: out_byte = 8'hdf;
         8'hf0: out_byte = 8'h8c; 8'hf1: out_byte = 8'ha1; 8'hf2: out_byte = 8'h89; 8'hf3: out_byte = 8'h0d; 8'hf4: out_byte = 8'hbf; 8'hf5: out_byte = 8'he6; 8'hf6: out_byte = 8'h42; 8'hf7: out_byte = 8'h68;
         8'hf8: out_byte = 8'h41; 8'hf9: out_byte = 8'h99; 8'hfa: out_byte = 8'h2d; 8'hfb: out_byte = 8'h0f; 8'hfc: out_byte = 8'hb0; 8'hfd: out_byte = 8'h54; 8'hfe: out_byte = 8'hbb; 8'hff: out_byte = 8'h16;
         default: out_byte = 8'h00;
      endcase
   end

endmodule

// File: rtl/key_schedule_iter.sv
// Iterative AES-128/192/256 key expander: one schedule word per clock into a word store,
// with a registered round-key read port for the round engine.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start; store holds last schedule (valid if ready)
//   ST_EXPAND | writing w[i] each clock until w[NW-1] is written
module key_schedule_iter
   import key_schedule_iter_pkg::*;
#(
   parameter int KEY_LEN = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [KEY_LEN-1:0] key,
   output logic               busy,
   output logic               done,
   output logic               ready,
   input  logic [3:0]         rk_idx,
   output logic [127:0]       rk_out
);

   localparam int NK = KEY_LEN / 32;
   localparam int NR = NK + 6;
   localparam int NW = NB * (NR + 1);

   localparam logic [5:0] NK_W   = 6'(NK);
   localparam logic [5:0] LAST_W = 6'(NW - 1);
   localparam logic [3:0] NR_W   = 4'(NR);

   if (!key_len_ok(KEY_LEN)) begin : g_bad_key_len
      $error("key_schedule_iter: KEY_LEN must be 128, 192 or 256");
   end

   ks_state_e     state_q, state_d;
   logic [5:0]    i_q, i_d;
   logic [7:0]    rcon_q, rcon_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ready_q, ready_d;
   logic [127:0]  rk_out_q, rk_out_d;

   logic [31:0]   w_mem [NW];
   logic          key_wr;
   logic          word_wr;

   logic [31:0]   t_word;
   logic [31:0]   old_word;
   logic [31:0]   new_word;
   logic [5:0]    i_mod;
   logic          rot_step;
   logic          sub_step;
   logic [31:0]   sub_in;
   logic [31:0]   sub_out;

   // Single SubWord path shared by every iteration that needs it
   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox_byte u_sbox (
         .in_byte  (sub_in[8*b +: 8]),
         .out_byte (sub_out[8*b +: 8])
      );
   end

   always_comb begin
      t_word   = w_mem[i_q - 6'd1];
      old_word = w_mem[i_q - NK_W];
      i_mod    = i_q % NK_W;
      rot_step = (i_mod == 6'd0);
      sub_step = (NK == 8) && (i_mod == 6'd4);
      sub_in   = rot_step ? {t_word[23:0], t_word[31:24]} : t_word;
      if (rot_step) begin
         new_word = old_word ^ sub_out ^ {rcon_q, 24'h0};
      end else if (sub_step) begin
         new_word = old_word ^ sub_out;
      end else begin
         new_word = old_word ^ t_word;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      rcon_d  = rcon_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ready_d = ready_q;
      key_wr  = 1'b0;
      word_wr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               key_wr  = 1'b1;
               i_d     = NK_W;
               rcon_d  = RCON_RST;
               busy_d  = 1'b1;
               ready_d = 1'b0;
               state_d = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            word_wr = 1'b1;
            i_d     = i_q + 6'd1;
            if (rot_step) begin
               rcon_d = xtime(rcon_q);
            end
            if (i_q == LAST_W) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Round-key read mux; the read address is always in range when rk_idx <= NR
   always_comb begin
      rk_out_d = 128'h0;
      if (rk_idx <= NR_W) begin
         rk_out_d = {w_mem[{rk_idx, 2'b00}], w_mem[{rk_idx, 2'b01}],
                     w_mem[{rk_idx, 2'b10}], w_mem[{rk_idx, 2'b11}]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         i_q      <= 6'd0;
         rcon_q   <= RCON_RST;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b0;
         rk_out_q <= 128'h0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         rcon_q   <= rcon_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
         rk_out_q <= rk_out_d;
      end
   end

   // Word store is deliberately not reset
   always_ff @(posedge clk) begin
      if (key_wr) begin
         for (int k = 0; k < NK; k++) begin
            w_mem[k] <= key[KEY_LEN-1-32*k -: 32];
         end
      end else if (word_wr) begin
         w_mem[i_q] <= new_word;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign ready  = ready_q;
   assign rk_out = rk_out_q;

endmodule

// File: tb/tb_key_schedule_iter.sv
// Directed bench for key_schedule_iter: one instance per key length, known-answer
// round keys, latency, done width, ignored restarts, mid-run reset and back-to-back start.
module tb_key_schedule_iter;

   localparam logic [127:0] KEY128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY128B  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [191:0] KEY192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] KEY256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [3:0]    rk_idx = 4'd0;

   logic          start128 = 1'b0, start192 = 1'b0, start256 = 1'b0;
   logic [127:0]  key128 = '0;
   logic [191:0]  key192 = '0;
   logic [255:0]  key256 = '0;
   logic          busy128, busy192, busy256;
   logic          done128, done192, done256;
   logic          ready128, ready192, ready256;
   logic [127:0]  rk128, rk192, rk256;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   key_schedule_iter #(.KEY_LEN(128)) u_dut128 (
      .clk(clk), .rst(rst), .start(start128), .key(key128), .busy(busy128),
      .done(done128), .ready(ready128), .rk_idx(rk_idx), .rk_out(rk128));

   key_schedule_iter #(.KEY_LEN(192)) u_dut192 (
      .clk(clk), .rst(rst), .start(start192), .key(key192), .busy(busy192),
      .done(done192), .ready(ready192), .rk_idx(rk_idx), .rk_out(rk192));

   key_schedule_iter #(.KEY_LEN(256)) u_dut256 (
      .clk(clk), .rst(rst), .start(start256), .key(key256), .busy(busy256),
      .done(done256), .ready(ready256), .rk_idx(rk_idx), .rk_out(rk256));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_rk(input logic [3:0] r);
      rk_idx = r;
      tick();
   endtask

   task automatic pulse_start128(input logic [127:0] k);
      start128 = 1'b1;
      key128   = k;
      tick();
      start128 = 1'b0;
   endtask

   task automatic wait_done128(output int lat);
      lat = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (done128) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat128, lat192, lat256;
      int nd128, nd192, nd256;
      int lat;

      #2 rst = 1'b1;
      tick();
      tick();
      check("rst_busy",  {127'h0, busy128},  128'h0);
      check("rst_done",  {127'h0, done128},  128'h0);
      check("rst_ready", {127'h0, ready128}, 128'h0);
      check("rst_rk",    rk128,              128'h0);
      rst = 1'b0;
      tick();

      // Start all three together; a second start with a different key mid-run must be ignored
      start128 = 1'b1; key128 = KEY128;
      start192 = 1'b1; key192 = KEY192;
      start256 = 1'b1; key256 = KEY256;
      tick();
      start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
      check("start_busy",  {127'h0, busy128},  128'h1);
      check("start_ready", {127'h0, ready128}, 128'h0);
      lat128 = 0; lat192 = 0; lat256 = 0;
      nd128 = 0; nd192 = 0; nd256 = 0;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (done128) begin nd128++; if (lat128 == 0) lat128 = k; end
         if (done192) begin nd192++; if (lat192 == 0) lat192 = k; end
         if (done256) begin nd256++; if (lat256 == 0) lat256 = k; end
         if (k == 5) begin
            start128 = 1'b1; key128 = ~KEY128;
            start192 = 1'b1; key192 = ~KEY192;
            start256 = 1'b1; key256 = ~KEY256;
         end
         if (k == 6) begin
            start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
         end
      end
      check("lat128",    128'(lat128), 128'd40);
      check("lat192",    128'(lat192), 128'd46);
      check("lat256",    128'(lat256), 128'd52);
      check("ndone128",  128'(nd128),  128'd1);
      check("ndone192",  128'(nd192),  128'd1);
      check("ndone256",  128'(nd256),  128'd1);
      check("ready_all", {125'h0, ready128, ready192, ready256}, 128'h7);
      check("busy_all",  {125'h0, busy128, busy192, busy256},    128'h0);

      read_rk(4'd0);
      check("k128_rk0", rk128, KEY128);
      check("k192_rk0", rk192, 128'h8e73b0f7da0e6452c810f32b809079e5);
      check("k256_rk0", rk256, 128'h603deb1015ca71be2b73aef0857d7781);
      read_rk(4'd1);
      check("k128_rk1", rk128, 128'ha0fafe1788542cb123a339392a6c7605);
      check("k192_rk1", rk192, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
      check("k256_rk1", rk256, 128'h1f352c073b6108d72d9810a30914dff4);
      read_rk(4'd2);
      check("k256_rk2", rk256, 128'h9ba354118e6925afa51a8b5f2067fcde);
      read_rk(4'd10);
      check("k128_rk10", rk128, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      read_rk(4'd11);
      check("k128_rk11", rk128, 128'h0);
      read_rk(4'd12);
      check("k192_rk12", rk192, 128'he98ba06f448c773c8ecc720401002202);
      read_rk(4'd13);
      check("k192_rk13", rk192, 128'h0);
      read_rk(4'd14);
      check("k256_rk14", rk256, 128'hfe4890d1e6188d0b046df344706c631e);
      read_rk(4'd15);
      check("k128_rk15", rk128, 128'h0);
      check("k192_rk15", rk192, 128'h0);
      check("k256_rk15", rk256, 128'h0);

      // Reset partway through a 128-bit expansion
      pulse_start128(KEY128B);
      repeat (20) tick();
      check("mid_busy", {127'h0, busy128}, 128'h1);
      rst = 1'b1;
      #1;
      check("mrst_busy",  {127'h0, busy128},  128'h0);
      check("mrst_ready", {127'h0, ready128}, 128'h0);
      check("mrst_rk",    rk128,              128'h0);
      tick();
      rst = 1'b0;
      nd128 = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (done128) nd128++;
      end
      check("mrst_nodone", 128'(nd128), 128'd0);
      check("mrst_idle",   {126'h0, busy128, ready128}, 128'h0);

      pulse_start128(KEY128);
      wait_done128(lat);
      check("re_lat", 128'(lat), 128'd40);
      // Back-to-back: start again on the edge right after done
      start128 = 1'b1;
      key128   = KEY128B;
      tick();
      start128 = 1'b0;
      check("b2b_done_width", {127'h0, done128}, 128'h0);
      check("b2b_ready_drop", {127'h0, ready128}, 128'h0);
      check("b2b_busy",       {127'h0, busy128},  128'h1);
      wait_done128(lat);
      check("b2b_lat",   128'(lat), 128'd40);
      check("b2b_ready", {127'h0, ready128}, 128'h1);
      read_rk(4'd0);
      check("b2b_rk0",  rk128, KEY128B);
      read_rk(4'd1);
      check("b2b_rk1",  rk128, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      read_rk(4'd10);
      check("b2b_rk10", rk128, 128'h13111d7fe3944a17f307a78b4d2b30c5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
